// File: rtl/cfg_ble_cluster.sv
// Cluster of NUM_BLE basic logic elements. Each element is a 4-input LUT
// followed by a flop that can be bypassed. LUT contents, bypass select and
// flop init value are loaded serially through one scan chain. A small
// sequencer moves the cluster through IDLE -> SHIFT -> LOAD -> RUN.
module cfg_ble_cluster #(
  parameter int NUM_BLE = 2
) (
  input  logic                 C,
  input  logic                 R,
  input  logic                 cfg_en,
  input  logic                 cfg_din,
  output logic                 cfg_dout,
  input  logic [NUM_BLE*4-1:0] in,
  input  logic [NUM_BLE-1:0]   ff_en,
  output logic [NUM_BLE-1:0]   out,
  output logic                 cfg_ok,
  output logic                 cfg_err,
  output logic                 running
);

  // Per-BLE slice: [15:0] LUT, [16] bypass, [17] flop init value.
  localparam int CFG_W     = 18;
  localparam int CHAIN_LEN = NUM_BLE * CFG_W;
  localparam int CW        = $clog2(CHAIN_LEN + 2);
  // The counter saturates one past the legal length, so an over-long
  // configuration can never wrap back round to look legal.
  localparam logic [CW-1:0] CNT_LEN = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(CHAIN_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t                 state_reg, state_next;
  logic [CHAIN_LEN-1:0]   chain_reg;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [NUM_BLE-1:0]     q_reg, q_next;
  logic                   cfg_ok_reg, cfg_err_reg;
  logic                   shift_en;
  logic [NUM_BLE-1:0]     lut_out;

  // Sequencer: next state, shift strobe and bit-count update.
  always_comb begin
    state_next = state_reg;
    shift_en   = 1'b0;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE, ST_RUN: begin
        if (cfg_en) begin
          shift_en   = 1'b1;
          cnt_next   = CW'(1);
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cfg_en) begin
          shift_en = 1'b1;
          cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counter and scan chain registers.
  always_ff @(posedge C) begin
    if (R) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      chain_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (shift_en) chain_reg <= {chain_reg[CHAIN_LEN-2:0], cfg_din};
    end
  end

  // Configuration status is captured only in LOAD and held otherwise.
  always_ff @(posedge C) begin
    if (R) begin
      cfg_ok_reg  <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else if (state_reg == ST_LOAD) begin
      cfg_ok_reg  <= (cnt_reg == CNT_LEN);
      cfg_err_reg <= (cnt_reg != CNT_LEN);
    end
  end

  assign running  = (state_reg == ST_RUN);
  assign cfg_dout = chain_reg[CHAIN_LEN-1];
  assign cfg_ok   = cfg_ok_reg;
  assign cfg_err  = cfg_err_reg;

  generate
    for (genvar gi = 0; gi < NUM_BLE; gi++) begin : g_ble
      logic [15:0] lut_bits;
      logic        byp;
      logic        init;

      assign lut_bits    = chain_reg[gi*CFG_W +: 16];
      assign byp         = chain_reg[gi*CFG_W + 16];
      assign init        = chain_reg[gi*CFG_W + 17];
      assign lut_out[gi] = lut_bits[in[gi*4 +: 4]];

      // Flop loads its init value in LOAD and only follows the LUT in RUN.
      assign q_next[gi] = (state_reg == ST_LOAD)              ? init        :
                          (state_reg == ST_RUN && ff_en[gi])  ? lut_out[gi] :
                                                                q_reg[gi];
      assign out[gi]    = running ? (byp ? lut_out[gi] : q_reg[gi]) : 1'b0;
    end
  endgenerate

  // BLE flops.
  always_ff @(posedge C) begin
    if (R) q_reg <= '0;
    else   q_reg <= q_next;
  end

endmodule

// File: doc/cfg_ble_cluster.md
Name: cfg_ble_cluster

Overview:
- Parametrised cluster of NUM_BLE basic logic elements (BLEs); each BLE is a 4-input LUT plus a bypassable flop.
- LUT contents, bypass select and flop init value load serially through an internal scan-style configuration chain.
- A small state machine sequences unconfigured -> shift -> load -> run and flags bad configuration lengths.
- Synthesisable sim/whitebox model for the next-generation fabric cluster.

Parameters:
- NUM_BLE, 2, number of BLEs in the cluster (1..16).
- CFG_W, 18, config bits per BLE. Fixed: 16 LUT bits, 1 bypass bit, 1 init bit. Not overridable.
- CHAIN_LEN, NUM_BLE*CFG_W, total chain length. Derived, localparam.

Ports:
- C  input  1  clock, all state updates on rising edge.
- R  input  1  reset, synchronous, active-high.
- cfg_en  input  1  shift enable for the configuration chain.
- cfg_din  input  1  serial config data in.
- cfg_dout  output  1  serial config data out, = chain[CHAIN_LEN-1], for daisy-chaining clusters.
- in  input  NUM_BLE*4  LUT inputs; BLE b uses in[4b+3:4b], in[4b] is the LSB of the LUT index.
- ff_en  input  NUM_BLE  per-BLE flop clock enable.
- out  output  NUM_BLE  BLE outputs.
- cfg_ok  output  1  last configuration shifted exactly CHAIN_LEN bits.
- cfg_err  output  1  last configuration shifted a bit count other than CHAIN_LEN.
- running  output  1  high in state RUN.

Behaviour:
- Chain layout: chain[CHAIN_LEN-1:0]. BLE b owns chain[b*18 +: 18].
  - Bits [15:0]: LUT, where LUT[i] is the output for index i = {in3,in2,in1,in0}.
  - Bit 16: BYP.
  - Bit 17: INIT.
- Shift (any cycle that shifts): chain[0]<=cfg_din, chain[k]<=chain[k-1]. The first bit shifted in ends up in chain[CHAIN_LEN-1], so data is MSB-first.
- lut_out[b] = LUT_b[in_b] (combinational). Q[b] is the BLE flop.
- States:
  - IDLE (after reset).
  - SHIFT.
  - LOAD.
  - RUN.
- Transitions and actions:
  - IDLE or RUN with cfg_en=1: shift this cycle, cnt<=1, go to SHIFT.
  - IDLE or RUN with cfg_en=0: stay.
  - SHIFT with cfg_en=1: shift, cnt<=min(cnt+1, CHAIN_LEN+1) (saturating), stay.
  - SHIFT with cfg_en=0: no shift, go to LOAD.
  - LOAD: one cycle only. Q[b]<=INIT_b; cfg_ok<=(cnt==CHAIN_LEN); cfg_err<=(cnt!=CHAIN_LEN); go to RUN. cfg_en is ignored in LOAD.
- RUN:
  - Q[b]<=lut_out[b] when ff_en[b]=1, else hold.
  - out[b] = BYP_b ? lut_out[b] : Q[b].
- IDLE, SHIFT, LOAD: out=0, Q holds (except the LOAD init load). ff_en is ignored.
- cfg_ok and cfg_err change only in LOAD and on reset; they hold through a later SHIFT until the next LOAD.
- Reset (R=1), highest priority over everything including cfg_en:
  - chain=0, Q=0, cnt=0, state=IDLE.
  - cfg_ok=0, cfg_err=0, running=0, out=0, cfg_dout=0.
- Reset mid-SHIFT: partial configuration is discarded (chain cleared).
- An erroneous configuration still enters RUN with whatever the chain holds; cfg_err is advisory.
- cnt width: $clog2(CHAIN_LEN+2).
- Latency:
  - Falling cfg_en -> LOAD on the next edge -> running=1 one edge later.
  - Bypassed BLE in RUN: 0-cycle path from in to out.
  - Registered BLE in RUN: 1-cycle path from in to out.

Test Plan:
- Reset, NUM_BLE=2, R=1 for 2 cycles with cfg_en=1, cfg_din=1 -> out=0, cfg_ok=0, cfg_err=0, running=0, cfg_dout=0.
- Shift 36 bits: BLE1 = INIT=0, BYP=1, LUT=16'h8000 (AND4); BLE0 = INIT=1, BYP=0, LUT=16'h6996 (XOR4). Drop cfg_en ->
  - LOAD, then running=1, cfg_ok=1, cfg_err=0.
  - out[0]=1 (init value) on the first RUN cycle.
  - in[7:4]=4'hF gives out[1]=1 combinationally; 4'hE gives 0.
- Registered BLE0 in RUN, in[3:0]=4'b0001, ff_en[0]=1 -> out[0]=1 one cycle later. ff_en[0]=0 with in=0 -> out[0] holds 1.
- Short/long config: shift 35 bits -> cfg_err=1, cfg_ok=0. Shift 40 bits -> cfg_err=1 (cnt saturates at 37, no wrap). First bit in exits on cfg_dout after 36 shifts.
- Reconfigure from RUN: raise cfg_en -> running=0 and out=0 from the next cycle. Assert R on the 10th shift -> IDLE, chain cleared, cfg_dout=0.
